// File: rtl/miner_dispatch.sv
// Block-job dispatcher: latches one job, interleaves the nonce space over NUM_CORES
// external hash cores and reports the first {hash, nonce} whose hash is below target.
module miner_dispatch #(
  parameter int NUM_CORES = 4,
  parameter int HDR_W     = 608,
  parameter int TGT_W     = 256,
  parameter int HASH_W    = 256,
  parameter int NONCE_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HDR_W+TGT_W-1:0]        rx_data,
  input  logic                          data_ready,
  output logic [HASH_W+NONCE_W-1:0]     tx_data,
  output logic                          send_data,
  output logic                          busy,
  output logic                          exhausted,
  output logic [HDR_W-1:0]              core_header,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*NONCE_W-1:0]  core_nonce,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*HASH_W-1:0]   core_hash
);

  // Extra headroom bits so nonce + NUM_CORES can never wrap, even for tiny NONCE_W.
  localparam int EXT_W = NONCE_W + 5;
  localparam logic [EXT_W-1:0] NONCE_MAX = {5'b0, {NONCE_W{1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_REPORT, S_DONE} state_t;

  state_t                      state_reg;
  logic [HDR_W-1:0]            header_reg;
  logic [TGT_W-1:0]            target_reg;
  logic [NONCE_W-1:0]          nonce_reg [NUM_CORES];
  logic [NUM_CORES-1:0]        outstanding_reg;
  logic [NUM_CORES-1:0]        retired_reg;
  logic [NUM_CORES-1:0]        start_reg;
  logic [HASH_W+NONCE_W-1:0]   tx_data_reg;
  logic                        send_data_reg;
  logic                        exhausted_reg;
  logic                        busy_reg;

  logic [HASH_W-1:0]           hash_w     [NUM_CORES];
  logic [NONCE_W-1:0]          step_nonce [NUM_CORES];
  logic [NONCE_W-1:0]          init_nonce [NUM_CORES];
  logic [NUM_CORES-1:0]        honoured;
  logic [NUM_CORES-1:0]        hit;
  logic [NUM_CORES-1:0]        can_step;
  logic [NUM_CORES-1:0]        start_ok;
  logic [NUM_CORES-1:0]        outstanding_next;
  logic [NUM_CORES-1:0]        retired_next;
  logic [NUM_CORES-1:0]        start_next;
  logic [HASH_W+NONCE_W-1:0]   hit_result;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [EXT_W-1:0] sum_w;
      assign hash_w[gi]     = core_hash[gi*HASH_W +: HASH_W];
      assign honoured[gi]   = core_done[gi] & outstanding_reg[gi];
      assign hit[gi]        = honoured[gi] & (hash_w[gi] < target_reg);
      assign sum_w          = {5'b0, nonce_reg[gi]} + EXT_W'(NUM_CORES);
      assign can_step[gi]   = (sum_w <= NONCE_MAX);
      assign step_nonce[gi] = sum_w[NONCE_W-1:0];
      // A core whose first nonce is already beyond the space never starts.
      assign start_ok[gi]   = (EXT_W'(gi) <= NONCE_MAX);
      assign init_nonce[gi] = NONCE_W'(gi);
      assign core_nonce[gi*NONCE_W +: NONCE_W] = nonce_reg[gi];
    end
  endgenerate

  always_comb begin
    outstanding_next = outstanding_reg & ~(honoured & ~can_step);
    retired_next     = retired_reg | (honoured & ~can_step);
    start_next       = honoured & can_step;
    hit_result       = '0;
    // Walk downwards so the lowest-index hitting core wins.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) hit_result = {hash_w[i], nonce_reg[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      header_reg      <= '0;
      target_reg      <= '0;
      outstanding_reg <= '0;
      retired_reg     <= '0;
      start_reg       <= '0;
      tx_data_reg     <= '0;
      send_data_reg   <= 1'b0;
      exhausted_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) nonce_reg[i] <= '0;
    end else begin
      start_reg     <= '0;
      send_data_reg <= 1'b0;
      exhausted_reg <= 1'b0;
      if (data_ready) begin
        // A new job is accepted from any state; it overrides any result this cycle.
        state_reg       <= S_LOAD;
        busy_reg        <= 1'b1;
        header_reg      <= rx_data[TGT_W +: HDR_W];
        target_reg      <= rx_data[TGT_W-1:0];
        start_reg       <= start_ok;
        outstanding_reg <= start_ok;
        retired_reg     <= ~start_ok;
        for (int i = 0; i < NUM_CORES; i++) nonce_reg[i] <= init_nonce[i];
      end else begin
        case (state_reg)
          S_IDLE: state_reg <= S_IDLE;
          S_LOAD: state_reg <= S_SEARCH;
          S_SEARCH: begin
            if (|hit) begin
              tx_data_reg     <= hit_result;
              send_data_reg   <= 1'b1;
              busy_reg        <= 1'b0;
              outstanding_reg <= '0;
              state_reg       <= S_REPORT;
            end else begin
              outstanding_reg <= outstanding_next;
              retired_reg     <= retired_next;
              start_reg       <= start_next;
              for (int i = 0; i < NUM_CORES; i++) begin
                if (start_next[i]) nonce_reg[i] <= step_nonce[i];
              end
              if (&retired_next && !(|outstanding_next)) begin
                exhausted_reg <= 1'b1;
                busy_reg      <= 1'b0;
                state_reg     <= S_DONE;
              end
            end
          end
          S_REPORT: state_reg <= S_IDLE;
          S_DONE:   state_reg <= S_IDLE;
          default:  state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_data     = tx_data_reg;
  assign send_data   = send_data_reg;
  assign exhausted   = exhausted_reg;
  assign busy        = busy_reg;
  assign core_header = header_reg;
  assign core_start  = start_reg;

endmodule

// File: tb/tb_miner_dispatch.sv
// Self-checking bench for miner_dispatch: behavioural hash cores plus a result scoreboard.
module tb_miner_dispatch;
  localparam int NC = 4, HDR_W = 608, TGT_W = 256, HASH_W = 256, NW = 4;
  localparam int RES_W = HASH_W + NW, LAT = 3;
  localparam int M_LIN = 0, M_REV = 1, M_SIM = 2;
  localparam logic [255:0] TGT_F = {4'hF, 252'h0};
  localparam logic [HDR_W-1:0] HDR_A = {19{32'hA5A5_0001}};
  localparam logic [HDR_W-1:0] HDR_B = {19{32'h0145_6789}};

  typedef struct packed {
    logic             is_exh;
    logic [RES_W-1:0] data;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [HDR_W+TGT_W-1:0]  rx_data = '0;
  logic                    data_ready = 1'b0;
  logic [RES_W-1:0]        tx_data;
  logic                    send_data, busy, exhausted;
  logic [HDR_W-1:0]        core_header;
  logic [NC-1:0]           core_start;
  logic [NC*NW-1:0]        core_nonce;
  logic [NC-1:0]           core_done = '0;
  logic [NC*HASH_W-1:0]    core_hash = '0;

  int tests_run = 0, tests_failed = 0;
  int mode = M_LIN;
  exp_t exp_q[$];
  logic [RES_W-1:0] last_tx = '0;

  int start_total = 0, send_total = 0, exh_total = 0;
  logic [15:0] issued [NC];
  bit both_seen = 1'b0;

  miner_dispatch #(.NUM_CORES(NC), .HDR_W(HDR_W), .TGT_W(TGT_W), .HASH_W(HASH_W), .NONCE_W(NW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
    .tx_data(tx_data), .send_data(send_data), .busy(busy), .exhausted(exhausted),
    .core_header(core_header), .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash)
  );

  always #5 clk = ~clk;

  function automatic logic [HASH_W-1:0] model_hash(input int m, input logic [NW-1:0] n);
    logic [3:0] r;
    r = 4'd15 - n;
    case (m)
      M_LIN:   return {n, 252'h0};
      M_REV:   return {r, 252'h0};
      M_SIM:   return (n == 4'd1 || n == 4'd3) ? '0 : '1;
      default: return '1;
    endcase
  endfunction

  // Behavioural cores: fixed latency, a new start replaces any pending work.
  logic [HASH_W-1:0] m_hash [NC];
  int  m_cnt  [NC];
  bit  m_pend [NC];
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      core_done[i] = 1'b0;
      if (rst) begin
        m_pend[i] = 1'b0;
      end else begin
        if (m_pend[i]) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_pend[i] = 1'b0;
            core_done[i] = 1'b1;
            core_hash[i*HASH_W +: HASH_W] = m_hash[i];
          end
        end
        if (core_start[i]) begin
          m_pend[i] = 1'b1;
          m_cnt[i]  = LAT;
          m_hash[i] = model_hash(mode, core_nonce[i*NW +: NW]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          start_total++;
          issued[i][core_nonce[i*NW +: NW]] = 1'b1;
        end
      end
      if (send_data) send_total++;
      if (exhausted) exh_total++;
      if (send_data && exhausted) both_seen = 1'b1;
    end
  end

  task automatic clear_issued();
    @(posedge clk);
    for (int i = 0; i < NC; i++) issued[i] = '0;
    @(negedge clk);
  endtask

  task automatic send_job(input logic [HDR_W-1:0] hdr, input logic [TGT_W-1:0] tgt);
    rx_data = {hdr, tgt};
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic wait_output(input int budget, output bit gs, output bit ge,
                             output logic [RES_W-1:0] d, output int cyc);
    gs = 1'b0; ge = 1'b0; d = '0; cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (send_data || exhausted) begin
        gs = send_data; ge = exhausted; d = tx_data; cyc = c + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({tx_data, send_data, busy, exhausted, core_start, core_nonce} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got tx=%h send=%b busy=%b exh=%b start=%b nonce=%h, want all zero",
               tx_data, send_data, busy, exhausted, core_start, core_nonce);
    end
    tests_run++;
    if (core_header !== '0) begin
      tests_failed++; $display("FAIL reset_header: got nonzero header, want 0");
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_first_hit();
    bit gs, ge; logic [RES_W-1:0] d; int cyc; exp_t e;
    mode = M_LIN;
    exp_q.push_back('{is_exh: 1'b0, data: {256'h0, 4'h0}});
    send_job(HDR_A, TGT_F);
    tests_run++;
    if (core_start !== 4'b1111 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL first_hit_load: got start=%b busy=%b, want 1111/1", core_start, busy);
    end
    tests_run++;
    if (core_nonce !== 16'h3210) begin
      tests_failed++; $display("FAIL first_hit_nonces: got %h, want 3210", core_nonce);
    end
    tests_run++;
    if (core_header !== HDR_A) begin
      tests_failed++; $display("FAIL first_hit_header: got %h, want %h", core_header[31:0], HDR_A[31:0]);
    end
    wait_output(40, gs, ge, d, cyc);
    e = exp_q.pop_front();
    last_tx = e.data;
    tests_run++;
    if (!gs || ge || d !== e.data) begin
      tests_failed++; $display("FAIL first_hit_result: got send=%b exh=%b tx=%h, want tx=%h", gs, ge, d, e.data);
    end
    tests_run++;
    if (cyc !== LAT + 1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL first_hit_latency: got %0d cycles busy=%b, want %0d busy=0", cyc, busy, LAT + 1);
    end
    @(negedge clk);
    tests_run++;
    if (send_data !== 1'b0) begin
      tests_failed++; $display("FAIL first_hit_pulse: send_data still %b, want 0", send_data);
    end
    $display("[TB] first_hit: tx=%h cycles=%0d", d, cyc);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_interleave();
    bit gs, ge; logic [RES_W-1:0] d; int cyc; exp_t e;
    clear_issued();
    mode = M_REV;
    exp_q.push_back('{is_exh: 1'b0, data: {4'h2, 252'h0, 4'd13}});
    send_job(HDR_A, {4'h3, 252'h0});
    wait_output(60, gs, ge, d, cyc);
    e = exp_q.pop_front();
    last_tx = e.data;
    tests_run++;
    if (!gs || ge || d !== e.data) begin
      tests_failed++; $display("FAIL interleave_result: got send=%b exh=%b tx=%h, want tx=%h", gs, ge, d, e.data);
    end
    tests_run++;
    if (issued[1] !== 16'h2222) begin
      tests_failed++; $display("FAIL interleave_core1: got issued %h, want 2222", issued[1]);
    end
    tests_run++;
    if (issued[2] !== 16'h4444) begin
      tests_failed++; $display("FAIL interleave_core2: got issued %h, want 4444", issued[2]);
    end
    $display("[TB] interleave: tx nonce=%0d core1 issued=%h", d[NW-1:0], issued[1]);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bit gs, ge; logic [RES_W-1:0] d; int cyc; exp_t e; int s0, p0;
    mode = M_SIM;
    s0 = start_total; p0 = send_total;
    exp_q.push_back('{is_exh: 1'b0, data: {256'h0, 4'd1}});
    send_job(HDR_B, {4'h1, 252'h0});
    wait_output(40, gs, ge, d, cyc);
    e = exp_q.pop_front();
    last_tx = e.data;
    tests_run++;
    if (!gs || ge || d !== e.data) begin
      tests_failed++; $display("FAIL simultaneous_result: got send=%b exh=%b tx=%h, want tx=%h", gs, ge, d, e.data);
    end
    repeat (8) @(negedge clk);
    tests_run++;
    if (send_total - p0 !== 1 || start_total - s0 !== 4) begin
      tests_failed++; $display("FAIL simultaneous_counts: got sends=%0d starts=%0d, want 1/4",
                               send_total - p0, start_total - s0);
    end
    $display("[TB] simultaneous: tx=%h", d);
  endtask

  task automatic test_back_to_back();
    bit gs, ge; logic [RES_W-1:0] d; int cyc; exp_t e;
    mode = M_LIN;
    exp_q.push_back('{is_exh: 1'b0, data: {256'h0, 4'h0}});
    send_job(HDR_A, TGT_F);
    wait_output(40, gs, ge, d, cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (!gs || d !== e.data) begin
      tests_failed++; $display("FAIL b2b_first: got send=%b tx=%h, want tx=%h", gs, d, e.data);
    end
    // New job arrives while REPORT is pulsing.
    mode = M_REV;
    exp_q.push_back('{is_exh: 1'b0, data: {4'hE, 252'h0, 4'd1}});
    send_job(HDR_B, TGT_F);
    tests_run++;
    if (core_start !== 4'b1111 || busy !== 1'b1 || send_data !== 1'b0 || core_header !== HDR_B) begin
      tests_failed++; $display("FAIL b2b_load: got start=%b busy=%b send=%b, want 1111/1/0", core_start, busy, send_data);
    end
    wait_output(40, gs, ge, d, cyc);
    e = exp_q.pop_front();
    last_tx = e.data;
    tests_run++;
    if (!gs || ge || d !== e.data) begin
      tests_failed++; $display("FAIL b2b_second: got send=%b tx=%h, want tx=%h", gs, d, e.data);
    end
    $display("[TB] back_to_back: tx=%h", d);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    bit gs, ge, found; logic [RES_W-1:0] d; int cyc; exp_t e; int p0;
    mode = M_LIN;
    p0 = send_total;
    send_job(HDR_A, TGT_F);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #1;
      if (core_done[0]) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL abort_wait: core_done never seen, want pulse within 20 cycles");
    end
    // Replace the job in the very cycle the old core 0 result would hit.
    rx_data = {HDR_B, TGT_F};
    data_ready = 1'b1;
    mode = M_REV;
    exp_q.push_back('{is_exh: 1'b0, data: {4'hE, 252'h0, 4'd1}});
    @(negedge clk);
    data_ready = 1'b0;
    tests_run++;
    if (core_start !== 4'b1111 || core_nonce !== 16'h3210 || send_data !== 1'b0) begin
      tests_failed++; $display("FAIL abort_restart: got start=%b nonce=%h send=%b, want 1111/3210/0",
                               core_start, core_nonce, send_data);
    end
    wait_output(40, gs, ge, d, cyc);
    e = exp_q.pop_front();
    last_tx = e.data;
    tests_run++;
    if (!gs || ge || d !== e.data || core_header !== HDR_B) begin
      tests_failed++; $display("FAIL abort_result: got send=%b tx=%h hdr=%h, want tx=%h hdr=%h",
                               gs, d, core_header[31:0], e.data, HDR_B[31:0]);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (send_total - p0 !== 1) begin
      tests_failed++; $display("FAIL abort_sends: got %0d send pulses, want 1", send_total - p0);
    end
    $display("[TB] abort: tx=%h", d);
  endtask

  task automatic test_exhaustion();
    bit gs, ge; logic [RES_W-1:0] d; int cyc; exp_t e; int s0, p0;
    logic [15:0] want;
    clear_issued();
    mode = M_LIN;
    s0 = start_total; p0 = send_total;
    exp_q.push_back('{is_exh: 1'b1, data: last_tx});
    send_job(HDR_A, '0);
    wait_output(80, gs, ge, d, cyc);
    e = exp_q.pop_front();
    tests_run++;
    if (gs || !ge || d !== e.data || busy !== 1'b0) begin
      tests_failed++; $display("FAIL exhaust_pulse: got send=%b exh=%b busy=%b tx=%h, want exh only tx=%h",
                               gs, ge, busy, d, e.data);
    end
    tests_run++;
    if (start_total - s0 !== 16) begin
      tests_failed++; $display("FAIL exhaust_starts: got %0d starts, want 16", start_total - s0);
    end
    for (int i = 0; i < NC; i++) begin
      want = 16'h1111 << i;
      tests_run++;
      if (issued[i] !== want) begin
        tests_failed++; $display("FAIL exhaust_core%0d: got issued %h, want %h", i, issued[i], want);
      end
    end
    @(negedge clk);
    tests_run++;
    if (exhausted !== 1'b0 || send_total !== p0) begin
      tests_failed++; $display("FAIL exhaust_after: got exh=%b sends=%0d, want 0/%0d", exhausted, send_total, p0);
    end
    $display("[TB] exhaustion: starts=%0d", start_total - s0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_search();
    int s0;
    mode = M_LIN;
    send_job(HDR_B, '0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({tx_data, send_data, busy, exhausted, core_start, core_nonce} !== '0 || core_header !== '0) begin
      tests_failed++; $display("FAIL midreset_outputs: got tx=%h busy=%b start=%b nonce=%h, want all zero",
                               tx_data, busy, core_start, core_nonce);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_tx = '0;
    s0 = start_total;
    repeat (10) @(negedge clk);
    tests_run++;
    if (start_total !== s0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_quiet: got %0d starts busy=%b, want 0/0", start_total - s0, busy);
    end
    $display("[TB] reset_mid_search done");
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (both_seen || exp_q.size() != 0) begin
      tests_failed++; $display("FAIL exclusive: got both=%b pending=%0d, want 0/0", both_seen, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NC; i++) issued[i] = '0;
    test_reset();
    test_first_hit();
    test_interleave();
    test_simultaneous();
    test_back_to_back();
    test_abort();
    test_exhaustion();
    test_reset_mid_search();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/miner_dispatch.md
Name: miner_dispatch

Overview:
- Parametrised job dispatcher that succeeds the single-core miner top level.
- Latches one block job: header (nonce field excluded) plus 256-bit target, using the same rx_data / data_ready convention.
- Splits the nonce space across NUM_CORES external hash cores (interleaved) and checks each returned hash against the target.
- Reports the first winning {hash, nonce} on tx_data with a send_data pulse. Adds exhaustion detection and abort/restart on a new job.

Parameters:
- NUM_CORES, 4, number of attached hash cores (1..16)
- HDR_W, 608, header bits sent to cores (76 bytes, nonce excluded)
- TGT_W, 256, target width; equal to HASH_W
- HASH_W, 256, core hash result width
- NONCE_W, 32, nonce width; the bench overrides it small for the exhaustion test

Ports:
- clk, in, 1, system clock, rising edge
- rst, in, 1, asynchronous active-high reset
- rx_data, in, HDR_W+TGT_W, job: {header[HDR_W-1:0], target[TGT_W-1:0]}
- data_ready, in, 1, one-cycle pulse: rx_data valid, start or replace the job
- tx_data, out, HASH_W+NONCE_W, result {hash, nonce}
- send_data, out, 1, one-cycle pulse: tx_data holds a winning result
- busy, out, 1, search in progress
- exhausted, out, 1, one-cycle pulse: full nonce space searched, no hit
- core_header, out, HDR_W, latched header, shared by all cores
- core_start, out, NUM_CORES, per-core one-cycle start pulse
- core_nonce, out, NUM_CORES*NONCE_W, per-core nonce, slice i = core i, stable while outstanding
- core_done, in, NUM_CORES, per-core one-cycle completion pulse
- core_hash, in, NUM_CORES*HASH_W, per-core hash, valid with core_done

Behaviour:
- Reset (async, any cycle): state IDLE; tx_data=0, send_data=0, busy=0, exhausted=0, core_start=0, core_nonce=0, core_header=0. All outstanding/retired flags cleared; target register=0.
- States: IDLE, LOAD, SEARCH, REPORT, DONE.
- IDLE:
  - data_ready=1 -> LOAD. Latch header to core_header and target.
  - Set core_nonce slice i = i for every core; clear retired/outstanding flags.
- LOAD (1 cycle):
  - busy=1.
  - core_start = all ones; every core i marked outstanding, except a core whose start nonce i exceeds 2^NONCE_W-1, which is retired immediately.
  - -> SEARCH.
- SEARCH:
  - Per core i, a core_done[i] pulse is honoured only while core i is outstanding; stray pulses are ignored.
  - On an honoured pulse, hit = (core_hash slice i < target), strict unsigned compare over HASH_W bits.
  - Any hit: select the lowest-index hitting core among those done this cycle. Register tx_data = {hash_i, nonce_i} -> REPORT. Issue no further core_start pulses.
  - Miss, with nonce_i + NUM_CORES <= 2^NONCE_W-1 (computed in NONCE_W+1 bits, no wrap): core_nonce slice i += NUM_CORES, core_start[i]=1 in the next cycle. Round trip = core latency + 1 cycle.
  - Miss, next nonce would overflow: core i retired, no start.
  - All cores retired and none outstanding, with no hit -> DONE.
- REPORT (1 cycle): send_data=1; tx_data holds its value until the next hit or reset. busy=0. -> IDLE. core_done pulses from cores still running are ignored.
- DONE (1 cycle): exhausted=1, busy=0, tx_data unchanged. -> IDLE.
- busy = 1 in LOAD and SEARCH only.
- data_ready during LOAD or SEARCH (abort):
  - Drop the current job and latch the new rx_data.
  - Reset nonces to i, clear outstanding/retired flags -> LOAD.
  - core_done pulses arriving in that same cycle are ignored; no send_data for the old job.
- data_ready in the same cycle as a hit: the abort wins and the hit is discarded.
- data_ready in REPORT or DONE: that state completes its pulse, and the job is accepted directly into LOAD next cycle instead of IDLE.
- send_data and exhausted are never asserted together; each is exactly one cycle.

Test Plan:
- Reset: rst=1 mid-SEARCH with NUM_CORES=4 -> all outputs 0 on the same clock edge; busy=0; no core_start after rst releases.
- First hit: target = 256'hF000...0, NUM_CORES=4, core model returns hash = nonce<<252 after 3 cycles. Nonces 0,1,2,3 issued in LOAD. Core 0 returns hash 0 < target -> send_data 1 cycle after core_done. tx_data = {256'h0, 32'h0}.
- Interleave: target=0x3<<252, core model returns hash = (15-nonce)<<252. Misses continue; core 1 later issued nonce 5, then 9. Nonce 13 (hash 0x2<<252) is the first hit; tx_data nonce=13, hash=0x2<<252.
- Simultaneous hits: cores 1 and 3 both hit in the same cycle -> tx_data carries core 1 hash and nonce; exactly one send_data.
- Exhaustion: NONCE_W=4, NUM_CORES=4, target=0 (never hit). Each core gets exactly 4 starts: core i issued i, i+4, i+8, i+12. Total 16 start pulses, then exhausted pulses once, busy=0, send_data never asserted.
- Abort: second data_ready (header nonce-field base 0x01456789...) mid-SEARCH -> next cycle core_start=4'b1111 with nonces 0..3. Old-job core_done ignored; subsequent hit reported with the new header on core_header.
